// File: rtl/wb_sram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | wb_sram_pkg : shared geometry, FSM states and helpers           |
// | Rev 1.0                                                          |
// +----------------------------------------------------------------+
package wb_sram_pkg;

  localparam int SRAM_AW    = 9;
  localparam int SRAM_DEPTH = 512;
  localparam int LANES      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Index width for the bank select; a single bank still gets a 1-bit index.
  function automatic int bank_bits(input int num_banks);
    int w;
    w = $clog2(num_banks);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf180_ram_512x8_wrapper.sv
`default_nettype none
// +----------------------------------------------------------------+
// | gf180_ram_512x8_wrapper : behavioural 512x8 macro, active-low    |
// | controls, Q updated on read and held otherwise. Rev 1.0          |
// +----------------------------------------------------------------+
module gf180_ram_512x8_wrapper (
  input  logic       CLK,
  input  logic       CEN,
  input  logic       GWEN,
  input  logic [7:0] WEN,
  input  logic [8:0] A,
  input  logic [7:0] D,
  output logic [7:0] Q
);

  logic [7:0] r_mem [512];

  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        r_mem[A] <= (r_mem[A] & WEN) | (D & ~WEN);
      end else begin
        Q <= r_mem[A];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_word_bank.sv
`default_nettype none
// +----------------------------------------------------------------+
// | sram_word_bank : one 512x32 bank from four byte-lane macros      |
// | Rev 1.0                                                          |
// +----------------------------------------------------------------+
module sram_word_bank
  import wb_sram_pkg::*;
(
  input  logic               clk,
  input  logic               i_cen_n,
  input  logic [SRAM_AW-1:0] i_addr,
  input  logic [LANES-1:0]   i_gwen_n,
  input  logic [31:0]        i_data,
  output logic [31:0]        o_q
);

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      gf180_ram_512x8_wrapper u_ram (
        .CLK  (clk),
        .CEN  (i_cen_n),
        .GWEN (i_gwen_n[l]),
        .WEN  (8'h00),
        .A    (i_addr),
        .D    (i_data[8*l +: 8]),
        .Q    (o_q[8*l +: 8])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/wb_sram_bank.sv
`default_nettype none
// +----------------------------------------------------------------+
// | wb_sram_bank : Wishbone classic slave over NUM_BANKS x 512x32    |
// | SRAM with wait states and abort handling. Rev 1.0                |
// +----------------------------------------------------------------+
module wb_sram_bank
  import wb_sram_pkg::*;
#(
  parameter int          NUM_BANKS   = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o
);

  localparam int          c_bank_w   = bank_bits(NUM_BANKS);
  localparam logic [31:0] c_win_mask = 32'(NUM_BANKS * 2048 - 1);
  localparam logic [2:0]  c_ws_load  = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t               r_state, w_next;
  logic [2:0]           r_wait_cnt, w_wait_cnt_nxt;
  logic [c_bank_w-1:0]  r_bank, w_bank;
  logic                 r_we, r_hit;
  logic                 w_req, w_hit, w_access, w_latch, w_ack;
  logic [SRAM_AW-1:0]   w_word;
  logic [LANES-1:0]     w_gwen_n;
  logic [NUM_BANKS-1:0] w_cen_n;
  logic [31:0]          w_bank_q [NUM_BANKS];
  logic [31:0]          w_rd_q;

  assign w_req    = wbs_cyc_i & wbs_stb_i;
  assign w_hit    = (wbs_adr_i & ~c_win_mask) == BASE_ADDR;
  assign w_bank   = c_bank_w'((wbs_adr_i >> 11) & 32'(NUM_BANKS - 1));
  assign w_word   = wbs_adr_i[10:2];
  assign w_gwen_n = ~({LANES{wbs_we_i}} & wbs_sel_i);
  // Macros are only touched in the request cycle, and never while reset is held.
  assign w_access = (r_state == IDLE) & w_req & w_hit & wb_rst_n_i;

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      assign w_cen_n[b] = ~(w_access & (w_bank == c_bank_w'(b)));

      sram_word_bank u_bank (
        .clk      (wb_clk_i),
        .i_cen_n  (w_cen_n[b]),
        .i_addr   (w_word),
        .i_gwen_n (w_gwen_n),
        .i_data   (wbs_dat_i),
        .o_q      (w_bank_q[b])
      );
    end
  endgenerate

  always_comb begin
    w_next         = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_latch        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_latch = 1'b1;
          if (WAIT_STATES > 0) begin
            w_next         = WAIT;
            w_wait_cnt_nxt = c_ws_load;
          end else begin
            w_next = RESP;
          end
        end
      end
      WAIT: begin
        if (!w_req) begin
          w_next         = IDLE;
          w_wait_cnt_nxt = 3'd0;
        end else if (r_wait_cnt == 3'd0) begin
          w_next = RESP;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - 3'd1;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state    <= IDLE;
      r_wait_cnt <= 3'd0;
      r_bank     <= '0;
      r_we       <= 1'b0;
      r_hit      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_latch) begin
        r_bank <= w_bank;
        r_we   <= wbs_we_i;
        r_hit  <= w_hit;
      end
    end
  end

  // Macro Q holds from the request edge because no CEN is issued in WAIT/RESP.
  assign w_rd_q    = w_bank_q[r_bank];
  assign w_ack     = (r_state == RESP) & w_req;
  assign wbs_ack_o = w_ack;
  assign wbs_dat_o = (w_ack & ~r_we & r_hit) ? w_rd_q : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_wb_sram_bank.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_wb_sram_bank : directed vectors for three wait-state builds   |
// | Rev 1.0                                                          |
// +----------------------------------------------------------------+
module tb_wb_sram_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc [3];
  logic        stb [3];
  logic        we  [3];
  logic [3:0]  sel [3];
  logic [31:0] adr [3];
  logic [31:0] dat [3];
  logic        ack [3];
  logic [31:0] rdat[3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int WS = (g == 0) ? 0 : (g == 1) ? 3 : 2;
      wb_sram_bank #(
        .NUM_BANKS   (2),
        .BASE_ADDR   (32'h3000_0000),
        .WAIT_STATES (WS)
      ) u_dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbs_cyc_i  (cyc[g]),
        .wbs_stb_i  (stb[g]),
        .wbs_we_i   (we[g]),
        .wbs_sel_i  (sel[g]),
        .wbs_adr_i  (adr[g]),
        .wbs_dat_i  (dat[g]),
        .wbs_ack_o  (ack[g]),
        .wbs_dat_o  (rdat[g])
      );
    end
  endgenerate

  typedef struct {
    bit          w;
    logic [3:0]  s;
    logic [31:0] a;
    logic [31:0] v;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus transaction; lat = edges until ack (-1 on timeout).
  // With hold set, stb stays up one more edge and ack is sampled again.
  task automatic xfer(input int d, input bit w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] v, input bit hold,
                      output logic [31:0] rd, output int lat, output logic ack_after);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; adr[d] = a; dat[d] = v;
    lat = -1; rd = 32'h0; ack_after = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (ack[d]) begin
        lat = n;
        rd  = rdat[d];
        break;
      end
    end
    if (hold && lat > 0) begin
      @(posedge clk); #1;
      ack_after = ack[d];
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    logic        aa;
    logic        seen;

    for (int i = 0; i < 3; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
      sel[i] = 4'h0; adr[i] = 32'h0; dat[i] = 32'h0;
    end

    // Reset held with an active write request on dut0
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; sel[0] = 4'hF;
    adr[0] = 32'h3000_0000; dat[0] = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", 32'(ack[0]), 32'h0);
    chk("reset_dat", rdat[0], 32'h0);
    chk("reset_cen", 32'(g_dut[0].u_dut.w_cen_n), 32'h3);
    cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_state", 32'(g_dut[0].u_dut.r_state), 32'h0);
    chk("post_reset_ack", 32'(ack[0]), 32'h0);

    // Main vectors on the zero-wait build
    vt.push_back('{1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, 32'h0});
    vt.push_back('{1'b0, 4'hF, 32'h3000_0004, 32'h0,         32'hDEAD_BEEF});
    vt.push_back('{1'b1, 4'hF, 32'h3000_0000, 32'hCAFE_F00D, 32'h0});
    vt.push_back('{1'b1, 4'hF, 32'h3000_0800, 32'h1122_3344, 32'h0});
    vt.push_back('{1'b1, 4'h1, 32'h3000_0800, 32'h0000_00AA, 32'h0});
    vt.push_back('{1'b0, 4'hF, 32'h3000_0800, 32'h0,         32'h1122_33AA});
    vt.push_back('{1'b0, 4'hF, 32'h3000_0000, 32'h0,         32'hCAFE_F00D});
    vt.push_back('{1'b1, 4'hA, 32'h3000_0800, 32'hAABB_CCDD, 32'h0});
    vt.push_back('{1'b0, 4'h0, 32'h3000_0803, 32'h0,         32'hAA22_CCAA});
    vt.push_back('{1'b1, 4'h0, 32'h3000_0004, 32'hFFFF_FFFF, 32'h0});
    vt.push_back('{1'b0, 4'hF, 32'h3000_0004, 32'h0,         32'hDEAD_BEEF});
    vt.push_back('{1'b1, 4'hF, 32'h4000_0000, 32'h5A5A_5A5A, 32'h0});
    vt.push_back('{1'b0, 4'hF, 32'h4000_0000, 32'h0,         32'h0});
    vt.push_back('{1'b1, 4'hF, 32'h3000_1000, 32'h5A5A_5A5A, 32'h0});
    vt.push_back('{1'b0, 4'hF, 32'h3000_1004, 32'h0,         32'h0});
    vt.push_back('{1'b0, 4'hF, 32'h3000_0000, 32'h0,         32'hCAFE_F00D});
    vt.push_back('{1'b0, 4'hF, 32'h3000_0800, 32'h0,         32'hAA22_CCAA});
    vt.push_back('{1'b1, 4'hF, 32'h3000_07FC, 32'h0BAD_CAFE, 32'h0});
    vt.push_back('{1'b1, 4'hF, 32'h3000_0FFC, 32'h1234_5678, 32'h0});
    vt.push_back('{1'b0, 4'hF, 32'h3000_07FE, 32'h0,         32'h0BAD_CAFE});
    vt.push_back('{1'b0, 4'hF, 32'h3000_0FFC, 32'h0,         32'h1234_5678});
    vt.push_back('{1'b0, 4'hF, 32'h3000_0004, 32'h0,         32'hDEAD_BEEF});

    foreach (vt[i]) begin
      xfer(0, vt[i].w, vt[i].s, vt[i].a, vt[i].v, 1'b0, rd, lat, aa);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
      chk($sformatf("vec%0d_dat", i), rd, vt[i].exp);
    end

    // Three wait states: ack on the fourth edge, one-cycle pulse
    xfer(1, 1'b1, 4'hF, 32'h3000_0008, 32'h1357_2468, 1'b0, rd, lat, aa);
    chk("ws3_wr_lat", 32'(lat), 32'd4);
    chk("ws3_wr_dat", rd, 32'h0);
    xfer(1, 1'b0, 4'hF, 32'h3000_0008, 32'h0, 1'b1, rd, lat, aa);
    chk("ws3_rd_lat", 32'(lat), 32'd4);
    chk("ws3_rd_dat", rd, 32'h1357_2468);
    chk("ws3_pulse", 32'(aa), 32'h0);

    // Abort during WAIT on a write (two wait states), then immediate read
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 4'hF;
    adr[2] = 32'h3000_0010; dat[2] = 32'h600D_D00D;
    @(posedge clk); #1;
    cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
    @(posedge clk); #1;
    seen = ack[2];
    chk("abort_state", 32'(g_dut[2].u_dut.r_state), 32'h0);
    chk("abort_no_ack", 32'(seen), 32'h0);
    xfer(2, 1'b0, 4'hF, 32'h3000_0010, 32'h0, 1'b0, rd, lat, aa);
    chk("abort_rd_lat", 32'(lat), 32'd3);
    chk("abort_rd_dat", rd, 32'h600D_D00D);

    // Asynchronous reset in the middle of a waited write
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF;
    adr[1] = 32'h3000_000C; dat[1] = 32'h0F0F_1234;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", 32'(g_dut[1].u_dut.r_state), 32'h0);
    chk("async_rst_ack", 32'(ack[1]), 32'h0);
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1, 1'b0, 4'hF, 32'h3000_000C, 32'h0, 1'b0, rd, lat, aa);
    chk("async_rst_rd_lat", 32'(lat), 32'd4);
    chk("async_rst_rd_dat", rd, 32'h0F0F_1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
